cu_microseq_q: RTL

Parametrised micro-code sequencer between instruction decode and the ALU. Buffers decoded instructions in a QDEPTH-entry FIFO, walks each instruction's micro-code sequence through a combinational micro-code ROM, and fuses the next instruction's first micro-op into the current instruction's last micro-op when the two control words are bit-disjoint. Supports pipeline flush, ALU back-pressure, and a saturating fusion counter for performance accounting.

---
 rtl/cu_microseq_q.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cu_microseq_q.sv
// Micro-code sequencer: FIFO of decoded instructions walked through an external ROM, fusing disjoint first/last micro-ops.
// First micro-op issues two cycles after an idle push; alu_stall freezes issue and pops while pushes continue until the FIFO is full.
module cu_microseq_q #(
    parameter int UADDR_W = 8,
    parameter int UCNT_W  = 3,
    parameter int UCODE_W = 32,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 8,
    parameter int QDEPTH  = 2,
    parameter int SPEC_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               alu_stall,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [UADDR_W-1:0] in_uaddr,
    input  logic [UCNT_W-1:0]  in_ucnt,
    input  logic [PC_W-1:0]    in_pc_nt,
    input  logic [PC_W-1:0]    in_br_pc,
    input  logic               in_br_pred,
    output logic [UADDR_W-1:0] uaddr_norm,
    input  logic [UCODE_W-1:0] ucode_norm_in,
    output logic [UADDR_W-1:0] uaddr_spec,
    input  logic [UCODE_W-1:0] ucode_spec_in,
    output logic               out_valid,
    output logic [UCODE_W-1:0] out_ucode,
    output logic               out_fused,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc_nt,
    output logic [PC_W-1:0]    out_br_pc,
    output logic               out_br_pred,
    output logic [15:0]        fuse_count
);
    localparam int PTR_W = $clog2(QDEPTH);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [UADDR_W-1:0] uaddr;
        logic [UCNT_W-1:0]  ucnt;
        logic [PC_W-1:0]    pc_nt;
        logic [PC_W-1:0]    br_pc;
        logic               br_pred;
    } entry_t;

    typedef enum logic {IDLE, RUN} state_t;

    entry_t             fifo_mem [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    state_t             state;
    logic [UADDR_W-1:0] act_addr;
    logic [UCNT_W-1:0]  act_rem;

    entry_t in_entry, head;
    logic   empty, full, act_valid, last, issue, fuse, push, pop;

    assign in_entry  = '{instr: in_instr, uaddr: in_uaddr, ucnt: in_ucnt,
                         pc_nt: in_pc_nt, br_pc: in_br_pc, br_pred: in_br_pred};
    assign head      = fifo_mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(QDEPTH));
    assign act_valid = (state == RUN);
    assign last      = act_valid && (act_rem == '0);
    assign issue     = act_valid && !alu_stall && !flush;
    assign fuse      = (SPEC_EN != 0) && last && !empty && (head.ucnt != '0)
                       && ((ucode_norm_in & ucode_spec_in) == '0);
    // A slot freed by a pop is only visible to the writer next cycle.
    assign push      = in_valid && !full;
    assign pop       = !alu_stall && !empty && (!act_valid || last);

    assign in_ready   = !full;
    assign out_valid  = issue;
    assign out_fused  = issue && fuse;
    assign out_ucode  = fuse ? (ucode_norm_in | ucode_spec_in) : ucode_norm_in;
    assign uaddr_norm = act_valid ? act_addr : '1;
    assign uaddr_spec = (last && !empty) ? head.uaddr : '1;

    always_ff @(posedge clk) begin
        if (!rst && !flush && push)
            fifo_mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            state       <= IDLE;
            act_addr    <= '0;
            act_rem     <= '0;
            out_instr   <= '0;
            out_pc_nt   <= '0;
            out_br_pc   <= '0;
            out_br_pred <= 1'b0;
            fuse_count  <= '0;
        end else begin
            if (out_fused && fuse_count != 16'hFFFF)
                fuse_count <= fuse_count + 16'd1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                state  <= IDLE;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
                if (pop) begin
                    state       <= RUN;
                    out_instr   <= head.instr;
                    out_pc_nt   <= head.pc_nt;
                    out_br_pc   <= head.br_pc;
                    out_br_pred <= head.br_pred;
                    // A fused head has already issued its first micro-op.
                    if (act_valid && fuse) begin
                        act_addr <= head.uaddr + UADDR_W'(1);
                        act_rem  <= head.ucnt - UCNT_W'(1);
                    end else begin
                        act_addr <= head.uaddr;
                        act_rem  <= head.ucnt;
                    end
                end else if (act_valid && !alu_stall) begin
                    if (act_rem != '0) begin
                        act_addr <= act_addr + UADDR_W'(1);
                        act_rem  <= act_rem - UCNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
            end
        end
    end
endmodule
